// File: rtl/multicycle_sequencer.sv
// Purpose : Moore FSM sequencing the shared RV64 datapath (fetch/regfile/ALU/dmem) over several cycles per instruction.
// Latency : R/I 4, ld 5, sd 4, beq 3 cycles with zero-wait memories; FETCH/MEM stretch while the awaited ready is low.
// Backpressure: holds in FETCH on !imem_ready and in MEM on !dmem_ready; traps (sticky until reset) after TIMEOUT waited cycles.
//
// Ports:
//   clock, reset (async, active-low)
//   opcode, zero, imem_ready, dmem_ready             : datapath status inputs
//   imem_req, ir_write, pc_write, pc_src, reg_write,
//   alu_src, alu_op, mem_read, mem_write, mem_to_reg : datapath controls, decoded from state (+ latched class)
//   state (debug encoding), trap (sticky error)
//   retired, stall_cycles                            : only when SEQ_PERF_CNT_EN is defined
//
// Optional feature macro: SEQ_PERF_CNT_EN (performance counters).

module multicycle_sequencer #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       reg_write,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic [2:0] state,
`ifdef SEQ_PERF_CNT_EN
    output logic [31:0] retired,
    output logic [31:0] stall_cycles,
`endif
    output logic       trap
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BRANCH = 3'd5,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_R   = 3'd0,
        C_I   = 3'd1,
        C_LD  = 3'd2,
        C_SD  = 3'd3,
        C_BEQ = 3'd4,
        C_ILL = 3'd5
    } cls_t;

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT);

    state_t           state_q, state_d;
    cls_t             cls_q, cls_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    function automatic cls_t decode_cls(input logic [6:0] opc);
        case (opc)
            7'b0110011: decode_cls = C_R;
            7'b0010011: decode_cls = C_I;
            7'b0000011: decode_cls = C_LD;
            7'b0100011: decode_cls = C_SD;
            7'b1100011: decode_cls = C_BEQ;
            default:    decode_cls = C_ILL;
        endcase
    endfunction

    // Next-state, class latch and wait counter
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_FETCH: begin
                // Ready on the terminal-count cycle still wins over the trap.
                if (imem_ready)              state_d = S_DECODE;
                else if (cnt_q == TERM_CNT)  state_d = S_TRAP;
                else                         cnt_d   = cnt_q + CNT_W'(1);
            end
            S_DECODE: begin
                cls_d = decode_cls(opcode);
                case (decode_cls(opcode))
                    C_R, C_I, C_LD, C_SD: state_d = S_EXEC;
                    C_BEQ:                state_d = S_BRANCH;
                    default:              state_d = S_TRAP;
                endcase
            end
            S_EXEC: begin
                if (cls_q == C_LD || cls_q == C_SD) state_d = S_MEM;
                else                                state_d = S_WB;
            end
            S_MEM: begin
                if (dmem_ready)              state_d = (cls_q == C_LD) ? S_WB : S_FETCH;
                else if (cnt_q == TERM_CNT)  state_d = S_TRAP;
                else                         cnt_d   = cnt_q + CNT_W'(1);
            end
            S_WB:     state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_TRAP;
        endcase
        // Each state's wait budget starts fresh.
        if (state_d != state_q) cnt_d = '0;
    end

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] retired_q, retired_d;
    logic [31:0] stall_q, stall_d;

    always_comb begin
        retired_d = retired_q;
        stall_d   = stall_q;
        if (state_q == S_WB || state_q == S_BRANCH ||
            (state_q == S_MEM && cls_q == C_SD && dmem_ready))
            retired_d = retired_q + 32'd1;
        if ((state_q == S_FETCH && !imem_ready) || (state_q == S_MEM && !dmem_ready))
            stall_d = stall_q + 32'd1;
    end

    assign retired      = retired_q;
    assign stall_cycles = stall_q;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            cls_q     <= C_R;
            cnt_q     <= '0;
`ifdef SEQ_PERF_CNT_EN
            retired_q <= '0;
            stall_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            cnt_q     <= cnt_d;
`ifdef SEQ_PERF_CNT_EN
            retired_q <= retired_d;
            stall_q   <= stall_d;
`endif
        end
    end

    // Control decode: pure function of state and latched class, except the
    // FETCH handshake (imem_ready) and the branch decision (zero).
    always_comb begin
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
                pc_write = imem_ready;
            end
            S_EXEC: begin
                case (cls_q)
                    C_R:     begin alu_src = 1'b0; alu_op = 2'b10; end
                    C_I:     begin alu_src = 1'b1; alu_op = 2'b10; end
                    default: begin alu_src = 1'b1; alu_op = 2'b00; end
                endcase
            end
            S_MEM: begin
                mem_read  = (cls_q == C_LD);
                mem_write = (cls_q == C_SD);
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (cls_q == C_LD);
            end
            S_BRANCH: begin
                alu_op   = 2'b01;
                pc_src   = 1'b1;
                pc_write = zero;
            end
            default: ;
        endcase
    end

    assign state = state_q;
    assign trap  = (state_q == S_TRAP);

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Moore FSM that sequences the shared RV64 datapath (fetch, register file, ALU, data memory) over multiple cycles per instruction.
- Replaces the single-cycle Main_Control decode for the multicycle build.
- Handles five opcode classes: R, I-ALU, ld, sd, beq.
- Stalls on instruction/data memory handshakes and traps on illegal opcodes or memory timeouts.

Parameters:
- TIMEOUT, 15: max cycles FETCH or MEM may wait for a ready before trapping; legal range 1..255.
- CNT_W, 8: width of the internal wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  7  instruction[6:0] from the instruction register.
- zero  in  1  ALU zero flag.
- imem_ready  in  1  instruction memory data valid this cycle.
- dmem_ready  in  1  data memory access complete this cycle.
- imem_req  out  1  instruction fetch request.
- ir_write  out  1  latch instruction register.
- pc_write  out  1  update PC.
- pc_src  out  1  0 = PC+4, 1 = branch target.
- reg_write  out  1  register file write enable.
- alu_src  out  1  0 = rs2, 1 = immediate.
- alu_op  out  2  00 add, 01 sub, 10 funct decode.
- mem_read  out  1  data memory read.
- mem_write  out  1  data memory write.
- mem_to_reg  out  1  writeback select: 1 = memory data.
- state  out  3  current state encoding (debug).
- trap  out  1  sticky error flag.

Behaviour:
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BRANCH=5, TRAP=7.
- reset low: state=FETCH, wait counter=0, trap=0 immediately (async).
- All outputs are combinational decodes of the state register, plus the opcode latched in DECODE. Two exceptions, both also gated by state:
  - ir_write and pc_write in FETCH = imem_ready.
  - pc_write in BRANCH = zero.
- FETCH:
  - imem_req=1 every cycle in FETCH.
  - imem_ready=1: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
  - Otherwise stay in FETCH and increment the wait counter.
- DECODE:
  - Latch the opcode class.
  - 0110011 (R), 0010011 (I), 0000011 (ld), 0100011 (sd): go to EXEC.
  - 1100011 (beq): go to BRANCH.
  - Any other opcode: go to TRAP.
- EXEC:
  - R: alu_src=0, alu_op=10, go to WB.
  - I: alu_src=1, alu_op=10, go to WB.
  - ld/sd: alu_src=1, alu_op=00, go to MEM.
- MEM:
  - ld: mem_read=1. sd: mem_write=1. Both held until dmem_ready.
  - On dmem_ready: ld goes to WB, sd goes to FETCH.
  - Otherwise increment the wait counter.
- WB:
  - reg_write=1 for exactly one cycle, then go to FETCH.
  - mem_to_reg=1 for ld, 0 for R/I.
- BRANCH:
  - alu_src=0, alu_op=01, pc_src=1, pc_write=zero, then go to FETCH.
  - Branch-target PC is written in this cycle.
- Wait counter:
  - Clears on every state change.
  - If it reaches TIMEOUT while still waiting in FETCH or MEM, go to TRAP on the next edge.
- TRAP:
  - trap=1, all enables 0, imem_req=0.
  - Exits only via reset.
- Minimum latency in cycles (with zero-wait memory):
  - R/I: 4.
  - ld: 5.
  - sd: 4.
  - beq: 3.
- Ready arriving on the same cycle the counter hits TIMEOUT: ready wins and no trap is raised.
- Ready asserted outside FETCH/MEM: ignored.
- Reset asserted mid-MEM: mem_read/mem_write drop asynchronously, and no write is committed by this block.
- No more than one of reg_write, mem_write, pc_write is ever 1 in a single cycle, except FETCH (pc_write + ir_write).

Optional Feature:
- Macro: SEQ_PERF_CNT_EN.
- When defined:
  - Adds outputs retired[31:0] and stall_cycles[31:0], both reset to 0.
  - retired increments on each transition out of WB, out of MEM for sd, and out of BRANCH.
  - stall_cycles increments on each cycle in FETCH or MEM where the awaited ready is 0.
  - Both counters wrap at 2^32 and hold their value in TRAP.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- R-type 0110011, imem_ready=1 and dmem_ready=1 tied high -> states 0,1,2,4,0; reg_write=1 only in cycle 4, alu_op=10, alu_src=0.
- ld 0000011, dmem_ready delayed 3 cycles -> MEM held 4 cycles with mem_read=1; WB has mem_to_reg=1, reg_write=1; total 8 cycles.
- beq 1100011, zero=1 then repeated with zero=0 -> BRANCH has alu_op=01, pc_src=1; pc_write=1 in the first run, 0 in the second; back to FETCH after 3 cycles.
- Opcode 1111111 -> DECODE goes to TRAP, trap=1, all enables 0; stays in TRAP for 20 cycles; reset low clears it to FETCH.
- imem_ready held 0 with TIMEOUT=15 -> state=7 after the counter reaches 15; ready on the terminal-count cycle instead -> DECODE with no trap.
- sd with reset pulsed low mid-MEM -> mem_write=0 and state=0 within the same cycle.
